mul_seq_ctrl: RTL and testbench

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

---
 rtl/mul_seq_ctrl_pkg.sv | 31 +++
 rtl/mul_seq_ctrl_wallace.sv | 56 +++++
 rtl/mul_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_mul_seq_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the sequential multiply controller: op and state
// encodings, settle-cycle limits and small product helpers.
package mul_seq_ctrl_pkg;

    localparam int MUL_CYCLES_MIN = 1;
    localparam int MUL_CYCLES_MAX = 4;
    localparam int CNT_W          = $clog2(MUL_CYCLES_MAX);

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // {rs1 treated as signed, rs2 treated as signed}
    function automatic logic [1:0] sign_mode(input op_e op);
        return {(op == OP_MULH) || (op == OP_MULHSU), op == OP_MULH};
    endfunction

    function automatic logic [31:0] word_sel(input logic [63:0] prod, input op_e op);
        return (op == OP_MUL) ? prod[31:0] : prod[63:32];
    endfunction

endpackage

// File: rtl/mul_seq_ctrl_wallace.sv
// Combinational 32x32 -> 64 multiplier built as a Wallace tree of 3:2
// carry-save compressors followed by a single carry-propagate add.
module Wallace_multiplier_64 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sign,
    output logic [63:0] product
);

    typedef logic [31:0][63:0] rows_t;

    // One tree level: every complete group of three rows becomes a sum row and
    // a carry row; leftover rows pass straight through.
    function automatic rows_t csa_level(input rows_t rows, input int n);
        rows_t nxt;
        int    groups;
        nxt    = '0;
        groups = n / 3;
        for (int g = 0; g < 10; g++) begin
            if (g < groups) begin
                nxt[5'(2*g)]   = rows[5'(3*g)] ^ rows[5'(3*g+1)] ^ rows[5'(3*g+2)];
                nxt[5'(2*g+1)] = ((rows[5'(3*g)]   & rows[5'(3*g+1)]) |
                                  (rows[5'(3*g)]   & rows[5'(3*g+2)]) |
                                  (rows[5'(3*g+1)] & rows[5'(3*g+2)])) << 1;
            end
        end
        for (int r = 0; r < 32; r++) begin
            if (r >= 3*groups && r < n)
                nxt[5'(r-groups)] = rows[5'(r)];
        end
        return nxt;
    endfunction

    function automatic logic [63:0] tree_mul(input logic [31:0] x, input logic [31:0] y,
                                             input logic is_signed);
        rows_t       rows;
        logic [63:0] ext_x;
        int          n;
        ext_x = is_signed ? {{32{x[31]}}, x} : {32'b0, x};
        for (int i = 0; i < 32; i++)
            rows[5'(i)] = y[5'(i)] ? (ext_x << i) : 64'd0;
        // Two's-complement multiplier MSB carries weight -2^31.
        if (is_signed && y[31])
            rows[31] = -(ext_x << 31);
        n = 32;
        // 32 -> 22 -> 15 -> 10 -> 7 -> 5 -> 4 -> 3 -> 2 rows
        for (int l = 0; l < 8; l++) begin
            rows = csa_level(rows, n);
            n    = n - n / 3;
        end
        return rows[0] + rows[1];
    endfunction

    assign product = tree_mul(a, b, sign);

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential RV32M multiply controller: accepts one request, lets the Wallace
// tree settle for MUL_CYCLES cycles, and reuses the last product on a repeat.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [4:0]  req_tag,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_tag,
    output logic        busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - MUL_CYCLES_MIN);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             entry_vld;

    logic [31:0] rs1_q, rs2_q;
    op_e         op_q;
    logic [4:0]  tag_q;

    logic [31:0] entry_rs1, entry_rs2;
    logic [63:0] entry_prod;
    logic [1:0]  entry_mode;

    logic [1:0]  req_mode, cur_mode;
    logic        rs1_neg, rs2_neg;
    logic [31:0] mag_a, mag_b;
    logic [63:0] mag_prod, result;
    logic        accept, hit, capture;

    assign req_ready = (state == ST_IDLE) || ((state == ST_DONE) && resp_ready);

    always_comb begin
        req_mode = sign_mode(op_e'(req_op));
        cur_mode = sign_mode(op_q);
        accept   = req_valid && req_ready && !flush;
        // Low product word does not depend on signedness, so MUL hits any entry.
        hit      = entry_vld && (req_rs1 == entry_rs1) && (req_rs2 == entry_rs2) &&
                   ((op_e'(req_op) == OP_MUL) || (req_mode == entry_mode));
        capture  = (state == ST_CALC) && !flush && (cnt == '0);
        rs1_neg  = cur_mode[1] & rs1_q[31];
        rs2_neg  = cur_mode[0] & rs2_q[31];
        mag_a    = rs1_neg ? -rs1_q : rs1_q;
        mag_b    = rs2_neg ? -rs2_q : rs2_q;
        result   = (rs1_neg ^ rs2_neg) ? -mag_prod : mag_prod;
    end

    // Multicycle path: rs1_q/rs2_q -> mag_a/mag_b -> tree -> result capture,
    // allotted MUL_CYCLES clock periods; operands are frozen throughout CALC.
    Wallace_multiplier_64 u_wallace (
        .a       (mag_a),
        .b       (mag_b),
        .sign    (1'b0),
        .product (mag_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            entry_vld  <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_tag   <= '0;
            busy       <= 1'b0;
        end else if (flush) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
        end else if (accept) begin
            busy <= 1'b1;
            if (hit) begin
                state      <= ST_DONE;
                resp_valid <= 1'b1;
                resp_data  <= word_sel(entry_prod, op_e'(req_op));
                resp_tag   <= req_tag;
            end else begin
                state      <= ST_CALC;
                resp_valid <= 1'b0;
                cnt        <= CNT_LOAD;
            end
        end else begin
            case (state)
                ST_CALC: begin
                    if (cnt == '0) begin
                        state      <= ST_DONE;
                        resp_valid <= 1'b1;
                        resp_data  <= word_sel(result, op_q);
                        resp_tag   <= tag_q;
                        entry_vld  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            rs1_q <= req_rs1;
            rs2_q <= req_rs2;
            op_q  <= op_e'(req_op);
            tag_q <= req_tag;
        end
        if (capture) begin
            entry_prod <= result;
            entry_rs1  <= rs1_q;
            entry_rs2  <= rs2_q;
            entry_mode <= cur_mode;
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: directed vector table, hand-written handshake,
// flush and reset sequences, then random traffic against a reference model.
module tb_mul_seq_ctrl;

    localparam int M = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_rs1 = '0;
    logic [31:0] req_rs2 = '0;
    logic [4:0]  req_tag = '0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic [4:0]  resp_tag;
    logic        busy;

    always #5 clk = ~clk;

    mul_seq_ctrl #(.MUL_CYCLES(M)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_tag    (req_tag),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state: last completed operation
    bit          m_vld = 1'b0;
    logic [31:0] m_rs1, m_rs2;
    logic [1:0]  m_mode;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
        bit          hit;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            2'b00:   p = 64'(ua * ub);
            2'b01:   p = 64'(sa * sb);
            2'b10:   p = 64'(sa * ub);
            default: p = {32'b0, a} * {32'b0, b};
        endcase
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [1:0] mode_of(input logic [1:0] op);
        case (op)
            2'b01:   return 2'b11;
            2'b10:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic bit model_hit(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        return m_vld && (a == m_rs1) && (b == m_rs2) && (op == 2'b00 || mode_of(op) == m_mode);
    endfunction

    task automatic model_store(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        m_vld  = 1'b1;
        m_rs1  = a;
        m_rs2  = b;
        m_mode = mode_of(op);
    endtask

    // Counts edges from the accepting edge until resp_valid is observed.
    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [31:0] exp, input int exp_lat,
                          input string name);
        int lat;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag;
        resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp(lat);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " data"}, 64'(resp_data), 64'(exp));
        check({name, " tag"}, 64'(resp_tag), 64'(tag));
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " req_ready"}, 64'(req_ready), 64'd1);
        check({name, " resp_valid"}, 64'(resp_valid), 64'd0);
        check({name, " resp_data"}, 64'(resp_data), 64'd0);
        check({name, " resp_tag"}, 64'(resp_tag), 64'd0);
        check({name, " busy"}, 64'(busy), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          lat;
        bit          h;
        bit          seen;
        logic [1:0]  op;
        logic [31:0] a, b, exp;
        logic [4:0]  tag;

        vecs[0] = '{2'b00, 32'h0000_0003, 32'hFFFF_FFFB, 5'd1, 32'hFFFF_FFF1, 1'b0};
        vecs[1] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 1'b0};
        vecs[2] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 1'b0};
        vecs[3] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 1'b0};
        vecs[4] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'h0000_0001, 1'b1};
        vecs[5] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 1'b0};
        vecs[6] = '{2'b01, 32'h0000_0007, 32'hFFFF_FFFE, 5'd7, 32'hFFFF_FFFF, 1'b0};
        vecs[7] = '{2'b01, 32'h0000_0007, 32'hFFFF_FFFE, 5'd8, 32'hFFFF_FFFF, 1'b1};

        // Reset
        #2 rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            h = model_hit(vecs[i].op, vecs[i].a, vecs[i].b);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp,
                   vecs[i].hit ? 1 : M + 1, $sformatf("vec%0d", i));
            if (!h) model_store(vecs[i].op, vecs[i].a, vecs[i].b);
        end

        // Response stall, then back-to-back acceptance on the releasing edge
        a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        exp = ref_word(2'b11, a, b);
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b11; req_rs1 = a; req_rs2 = b; req_tag = 5'd9;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp(lat);
        check("stall latency", 64'(lat), 64'(M + 1));
        model_store(2'b11, a, b);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("stall resp_valid", 64'(resp_valid), 64'd1);
            check("stall resp_data", 64'(resp_data), 64'(exp));
            check("stall resp_tag", 64'(resp_tag), 64'd9);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        req_valid = 1'b1; req_op = 2'b00; req_rs1 = 32'h1000; req_rs2 = 32'h1000; req_tag = 5'd10;
        #1 check("b2b req_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; resp_ready = 1'b0;
        check("b2b busy", 64'(busy), 64'd1);
        check("b2b resp_valid dropped", 64'(resp_valid), 64'd0);
        wait_resp(lat);
        check("b2b latency", 64'(lat), 64'(M + 1));
        check("b2b data", 64'(resp_data), 64'h0100_0000);
        check("b2b tag", 64'(resp_tag), 64'd10);
        model_store(2'b00, 32'h1000, 32'h1000);
        @(negedge clk); resp_ready = 1'b1;
        @(posedge clk); #1; resp_ready = 1'b0;
        check("b2b drain busy", 64'(busy), 64'd0);

        // Flush in the first CALC cycle
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b00; req_rs1 = 32'h55; req_rs2 = 32'h66; req_tag = 5'd11;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("flush pre busy", 64'(busy), 64'd1);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        check("flush resp_valid", 64'(resp_valid), 64'd0);
        check("flush req_ready", 64'(req_ready), 64'd1);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            seen |= resp_valid;
        end
        check("flush no response", 64'(seen), 64'd0);
        // Request alongside flush is dropped
        @(negedge clk);
        req_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        check("flush discards request", 64'(busy), 64'd0);
        h = model_hit(2'b00, 32'h55, 32'h66);
        run_op(2'b00, 32'h55, 32'h66, 5'd12, ref_word(2'b00, 32'h55, 32'h66),
               h ? 1 : M + 1, "flush retry");
        if (!h) model_store(2'b00, 32'h55, 32'h66);

        // Asynchronous reset while holding a result in DONE
        a = 32'hDEAD_BEEF; b = 32'h0001_2345;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b11; req_rs1 = a; req_rs2 = b; req_tag = 5'd13;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp(lat);
        check("pre-reset latency", 64'(lat), 64'(M + 1));
        check("pre-reset data", 64'(resp_data), 64'(ref_word(2'b11, a, b)));
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async reset");
        @(negedge clk); rst_n = 1'b1;
        m_vld = 1'b0;
        run_op(2'b11, a, b, 5'd14, ref_word(2'b11, a, b), M + 1, "post-reset miss");
        model_store(2'b11, a, b);

        // Random traffic
        a = pick(); b = pick();
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0) begin
                a = pick(); b = pick();
            end
            tag = 5'($urandom);
            h = model_hit(op, a, b);
            run_op(op, a, b, tag, ref_word(op, a, b), h ? 1 : M + 1, $sformatf("rand%0d", i));
            if (!h) model_store(op, a, b);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
